// File: rtl/rx_cmd_output_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_cmd_output_ctrl
// Description : Decodes single-byte UART commands into per-channel timed
//               output pulses. Byte CMD_BASE+i switches channel i on for
//               ON_CYCLES clocks; OFF_CMD switches every channel off; any
//               other byte raises a one-cycle command-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_cmd_output_ctrl #(
   parameter int         NUM_CH    = 4,
   parameter logic [7:0] CMD_BASE  = 8'd54,
   parameter logic [7:0] OFF_CMD   = 8'd48,
   parameter int         ON_CYCLES = 50000000,
   parameter int         CNT_W     = 26,
   parameter int         RETRIGGER = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxDone,
   input  logic [7:0]        rxData,
   output logic [NUM_CH-1:0] outControl,
   output logic [NUM_CH-1:0] doneStrobe,
   output logic              cmdErr,
   output logic              busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ON   = 1'b1
   } ch_state_t;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   logic              r_rx_d;      // rxDone history (previous cycle)
   logic              r_rx_armed;  // rxDone has been seen low since reset
   logic              r_cmd_err;
   logic              w_accept;
   logic              w_off;
   logic [NUM_CH-1:0] w_hit_vec;

   // A byte is taken only on a rising rxDone. The armed flag keeps a strobe
   // that was already high when reset released from counting as a new edge.
   assign w_accept = rxDone && !r_rx_d && r_rx_armed;
   assign w_off    = w_accept && (rxData == OFF_CMD);

   // rxDone edge-detect history and post-reset arming
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_d     <= 1'b0;
         r_rx_armed <= 1'b0;
      end else begin
         r_rx_d     <= rxDone;
         r_rx_armed <= r_rx_armed || !rxDone;
      end
   end

   // Error pulse for an accepted byte that matches no command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_err <= 1'b0;
      end else begin
         r_cmd_err <= w_accept && !w_off && (w_hit_vec == '0);
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [7:0] c_cmd = 8'(CMD_BASE + gi);

      ch_state_t        r_state;
      ch_state_t        w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_done;
      logic             w_done_nxt;

      assign w_hit_vec[gi] = w_accept && (rxData == c_cmd);

      // Channel state, on-time counter and done pulse registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
         end
      end

      // Next state: OFF beats everything, then (re)activation, then timing.
      // A retrigger landing on the expiry cycle restarts instead of expiring.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_done_nxt  = 1'b0;
         if (w_off) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end else if (w_hit_vec[gi] && ((r_state == S_IDLE) || (RETRIGGER != 0))) begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
         end else if (r_state == S_ON) begin
            if (r_cnt == c_last) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + c_one;
            end
         end
      end

      assign outControl[gi] = (r_state == S_ON);
      assign doneStrobe[gi] = r_done;
   end

   assign cmdErr = r_cmd_err;
   assign busy   = |outControl;

endmodule
`default_nettype wire

// File: tb/tb_rx_cmd_output_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_cmd_output_ctrl
// Description : Directed self-checking bench. Two instances (retrigger on /
//               off) share stimulus; a remaining-on-time model is compared
//               every cycle, and literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_cmd_output_ctrl;

   localparam int C_BASE = 54;
   localparam int C_OFF  = 48;
   localparam int C_ON   = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxDone;
   logic [7:0] rxData;

   logic [3:0] out1, dn1, out0, dn0;
   logic       err1, busy1, err0, busy0;

   int n_tests = 0;
   int n_fail  = 0;

   rx_cmd_output_ctrl #(
      .NUM_CH(4), .CMD_BASE(8'd54), .OFF_CMD(8'd48),
      .ON_CYCLES(C_ON), .CNT_W(4), .RETRIGGER(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .rxDone(rxDone), .rxData(rxData),
      .outControl(out1), .doneStrobe(dn1), .cmdErr(err1), .busy(busy1)
   );

   rx_cmd_output_ctrl #(
      .NUM_CH(4), .CMD_BASE(8'd54), .OFF_CMD(8'd48),
      .ON_CYCLES(C_ON), .CNT_W(4), .RETRIGGER(0)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rxDone(rxDone), .rxData(rxData),
      .outControl(out0), .doneStrobe(dn0), .cmdErr(err0), .busy(busy0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: remaining on-cycles per channel ----
   int         rem1 [4];
   int         rem0 [4];
   logic [3:0] m_done1, m_done0;
   logic       m_err, m_prev, m_armed;
   wire        m_acc = rxDone && !m_prev && m_armed;

   function automatic int nxt_rem(int rem, bit hit, bit off, bit retrig);
      if (off) return 0;
      if (hit && (rem == 0 || retrig)) return C_ON;
      if (rem > 0) return rem - 1;
      return 0;
   endfunction

   function automatic bit expires(int rem, bit hit, bit off, bit retrig);
      return !off && !(hit && (rem == 0 || retrig)) && rem == 1;
   endfunction

   function automatic logic [3:0] onvec(int r [4]);
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = (r[i] > 0);
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            rem1[i] <= 0;
            rem0[i] <= 0;
         end
         m_done1 <= '0;
         m_done0 <= '0;
         m_err   <= 1'b0;
         m_prev  <= 1'b0;
         m_armed <= 1'b0;
      end else begin
         m_prev  <= rxDone;
         m_armed <= m_armed || !rxDone;
         m_err   <= m_acc && (int'(rxData) != C_OFF) &&
                    !((int'(rxData) >= C_BASE) && (int'(rxData) < C_BASE + 4));
         for (int i = 0; i < 4; i++) begin
            rem1[i]    <= nxt_rem(rem1[i], m_acc && int'(rxData) == C_BASE + i,
                                  m_acc && int'(rxData) == C_OFF, 1'b1);
            rem0[i]    <= nxt_rem(rem0[i], m_acc && int'(rxData) == C_BASE + i,
                                  m_acc && int'(rxData) == C_OFF, 1'b0);
            m_done1[i] <= expires(rem1[i], m_acc && int'(rxData) == C_BASE + i,
                                  m_acc && int'(rxData) == C_OFF, 1'b1);
            m_done0[i] <= expires(rem0[i], m_acc && int'(rxData) == C_BASE + i,
                                  m_acc && int'(rxData) == C_OFF, 1'b0);
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("mdl_out_rt1",  8'(out1),  8'(onvec(rem1)));
      chk("mdl_done_rt1", 8'(dn1),   8'(m_done1));
      chk("mdl_err_rt1",  8'(err1),  8'(m_err));
      chk("mdl_busy_rt1", 8'(busy1), 8'(|onvec(rem1)));
      chk("mdl_out_rt0",  8'(out0),  8'(onvec(rem0)));
      chk("mdl_done_rt0", 8'(dn0),   8'(m_done0));
      chk("mdl_err_rt0",  8'(err0),  8'(m_err));
      chk("mdl_busy_rt0", 8'(busy0), 8'(|onvec(rem0)));
   end

   // ---------------- directed stimulus -------------------------------------
   logic       sd   [32];
   logic [7:0] sdat [32];
   logic [3:0] so1 [32], so0 [32], sdn1 [32], sdn0 [32];
   logic       serr [32], sbusy [32];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_seq();
      for (int k = 0; k < 32; k++) begin
         sd[k]   = 1'b0;
         sdat[k] = 8'd0;
      end
   endtask

   task automatic set_seq(input int k, input logic [7:0] d);
      sd[k]   = 1'b1;
      sdat[k] = d;
   endtask

   // Sample k reflects the outputs after the edge that consumed vector k
   task automatic run_seq(input int n);
      for (int k = 0; k < n; k++) begin
         rxDone = sd[k];
         rxData = sdat[k];
         tick();
         so1[k]   = out1;
         so0[k]   = out0;
         sdn1[k]  = dn1;
         sdn0[k]  = dn0;
         serr[k]  = err1;
         sbusy[k] = busy1;
      end
      rxDone = 1'b0;
      rxData = 8'd0;
      clear_seq();
   endtask

   function automatic int popc(logic [3:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
   endfunction

   initial begin
      int h1, h0, d1, d0;
      rst_n  = 1'b1;
      rxDone = 1'b0;
      rxData = 8'd0;
      clear_seq();
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out",  8'(out1),  8'h00);
      chk("rst_done", 8'(dn1),   8'h00);
      chk("rst_err",  8'(err1),  8'h00);
      chk("rst_busy", 8'(busy1), 8'h00);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Single activation of channel 1
      set_seq(0, 8'd55);
      run_seq(14);
      h1 = 0; d1 = 0;
      for (int k = 0; k < 14; k++) begin
         h1 += int'(so1[k][1]);
         d1 += int'(sdn1[k][1]);
      end
      chk("ch1_high_cycles", 8'(h1), 8'd10);
      chk("ch1_done_count",  8'(d1), 8'd1);
      chk("ch1_last_on",     8'(so1[9]),   8'h02);
      chk("ch1_off_after",   8'(so1[10]),  8'h00);
      chk("ch1_done_pulse",  8'(sdn1[10]), 8'h02);
      chk("ch1_busy_after",  8'(sbusy[10]), 8'h00);

      // rxDone held high five cycles: one activation only
      for (int k = 0; k < 5; k++) set_seq(k, 8'd54);
      run_seq(16);
      h1 = 0; d1 = 0;
      for (int k = 0; k < 16; k++) begin
         h1 += int'(so1[k][0]);
         d1 += int'(sdn1[k][0]);
      end
      chk("hold_high_cycles", 8'(h1), 8'd10);
      chk("hold_done_count",  8'(d1), 8'd1);

      // Retrigger six cycles after activation
      set_seq(0, 8'd54);
      set_seq(6, 8'd54);
      run_seq(22);
      h1 = 0; h0 = 0; d1 = 0; d0 = 0;
      for (int k = 0; k < 22; k++) begin
         h1 += int'(so1[k][0]);
         h0 += int'(so0[k][0]);
         d1 += int'(sdn1[k][0]);
         d0 += int'(sdn0[k][0]);
      end
      chk("retrig1_high", 8'(h1), 8'd16);
      chk("retrig0_high", 8'(h0), 8'd10);
      chk("retrig1_done", 8'(d1), 8'd1);
      chk("retrig0_done", 8'(d0), 8'd1);

      // Channels 0 and 3 on, then OFF command
      set_seq(0, 8'd54);
      set_seq(2, 8'd57);
      set_seq(4, 8'd48);
      run_seq(8);
      d1 = 0;
      for (int k = 0; k < 8; k++) d1 += popc(sdn1[k]);
      chk("off_before", 8'(so1[3]), 8'h09);
      chk("off_after",  8'(so1[4]), 8'h00);
      chk("off_nodone", 8'(d1),     8'd0);

      // Unknown byte while channel 2 is on
      set_seq(0, 8'd56);
      set_seq(2, 8'd65);
      run_seq(14);
      chk("err_pulse",   8'(serr[2]), 8'h01);
      chk("err_one_cyc", 8'(serr[3]), 8'h00);
      chk("err_out_at",  8'(so1[2]),  8'h04);
      chk("err_out_nxt", 8'(so1[3]),  8'h04);

      // Reset in the middle of an activation, strobe still high on release
      set_seq(0, 8'd56);
      run_seq(4);
      rxDone = 1'b1;
      rxData = 8'd54;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out",  8'(out1), 8'h00);
      chk("arst_done", 8'(dn1),  8'h00);
      chk("arst_busy", 8'(busy1), 8'h00);
      repeat (2) tick();
      rst_n = 1'b1;
      h1 = 0; d1 = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         h1 += popc(out1);
         d1 += popc(dn1);
      end
      chk("rel_no_act",  8'(h1), 8'd0);
      chk("rel_no_done", 8'(d1), 8'd0);
      rxDone = 1'b0;
      repeat (2) tick();
      set_seq(0, 8'd54);
      run_seq(12);
      h1 = 0;
      for (int k = 0; k < 12; k++) h1 += int'(so1[k][0]);
      chk("rel_new_act", 8'(h1), 8'd10);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
